rv_alu: RTL and testbench

- 32-bit integer ALU for the single-cycle RISC-V datapath (RV32I arithmetic, logic, shift and compare ops, plus a pass-B move used for LUI-style writes).
- Combinational compute core with a registered output stage (result plus status flags) clocked by the core clock.
- Fed by the register file and immediate mux; drives writeback and branch-compare logic.

---
 rtl/rv_alu_pkg.sv | 24 ++
 rtl/rv_alu_core.sv | 49 ++++
 rtl/rv_alu.sv | 80 ++++++++
 tb/tb_rv_alu.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/rv_alu_pkg.sv
// Shared types and constants for the RV32I ALU.
//   XLEN     : operand/result width
//   SHAMT_W  : low bits of B used as shift amount
//   alu_op_e : ALUOp encoding ({funct7[5], funct3}-style)
package rv_alu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101,
        ALU_MOV  = 4'b1111
    } alu_op_e;

endpackage

// File: rtl/rv_alu_core.sv
// Combinational ALU core: (A, B, op) -> result, illegal.
// Ports:
//   a_i, b_i     : operands (two's complement)
//   alu_op_i     : operation select (alu_op_e encoding)
//   result_c_o   : combinational result (0 for undefined ops)
//   illegal_c_o  : combinational flag, op is not a defined encoding
module rv_alu_core
    import rv_alu_pkg::*;
#(
    parameter int unsigned W     = XLEN,
    parameter int unsigned SH_W  = SHAMT_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [3:0]   alu_op_i,
    output logic [W-1:0] result_c_o,
    output logic         illegal_c_o
);

    logic [SH_W-1:0] shamt;
    logic            lt_signed;
    logic            lt_unsigned;

    // Only the low bits of B select the shift distance.
    assign shamt       = b_i[SH_W-1:0];
    assign lt_signed   = $signed(a_i) < $signed(b_i);
    assign lt_unsigned = a_i < b_i;

    // Operation decode; defaults cover the undefined encodings.
    always_comb begin
        result_c_o  = '0;
        illegal_c_o = 1'b0;
        case (alu_op_e'(alu_op_i))
            ALU_ADD:  result_c_o = a_i + b_i;
            ALU_SUB:  result_c_o = a_i - b_i;
            ALU_SLL:  result_c_o = a_i << shamt;
            ALU_SLT:  result_c_o = W'(lt_signed);
            ALU_SLTU: result_c_o = W'(lt_unsigned);
            ALU_XOR:  result_c_o = a_i ^ b_i;
            ALU_SRL:  result_c_o = a_i >> shamt;
            ALU_SRA:  result_c_o = W'($signed(a_i) >>> shamt);
            ALU_OR:   result_c_o = a_i | b_i;
            ALU_AND:  result_c_o = a_i & b_i;
            ALU_MOV:  result_c_o = b_i;
            default:  illegal_c_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv_alu.sv
// RV32I ALU with a one-cycle registered output stage.
// Ports:
//   clk, rst   : core clock, synchronous active-high reset
//   A, B       : operands; shift amount in B[SHAMT_W-1:0]
//   ALUOp      : operation select
//   in_valid   : operands/op valid this cycle
//   ALURes     : registered result
//   out_valid  : in_valid delayed one cycle
//   zero       : registered, ALURes == 0
//   illegal_op : registered, ALUOp was undefined
module rv_alu
    import rv_alu_pkg::*;
#(
    parameter int unsigned XLEN_P    = XLEN,
    parameter int unsigned SHAMT_W_P = SHAMT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN_P-1:0] A,
    input  logic [XLEN_P-1:0] B,
    input  logic [3:0]        ALUOp,
    input  logic              in_valid,
    output logic [XLEN_P-1:0] ALURes,
    output logic              out_valid,
    output logic              zero,
    output logic              illegal_op
);

    logic [XLEN_P-1:0] res_c;
    logic              illegal_c;

    logic [XLEN_P-1:0] res_d, res_q;
    logic              zero_d, zero_q;
    logic              illegal_d, illegal_q;
    logic              valid_q;

    rv_alu_core #(
        .W    (XLEN_P),
        .SH_W (SHAMT_W_P)
    ) u_core (
        .a_i         (A),
        .b_i         (B),
        .alu_op_i    (ALUOp),
        .result_c_o  (res_c),
        .illegal_c_o (illegal_c)
    );

    // Capture a new result only on valid input; otherwise hold.
    always_comb begin
        res_d     = res_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        if (in_valid) begin
            res_d     = res_c;
            zero_d    = (res_c == '0);
            illegal_d = illegal_c;
        end
    end

    // Output registers; reset wins over a same-cycle operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q     <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            res_q     <= res_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            valid_q   <= in_valid;
        end
    end

    assign ALURes     = res_q;
    assign zero       = zero_q;
    assign illegal_op = illegal_q;
    assign out_valid  = valid_q;

endmodule

// File: tb/tb_rv_alu.sv
// Directed self-checking bench for rv_alu.
module tb_rv_alu;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUOp;
    logic        in_valid;
    logic [31:0] ALURes;
    logic        out_valid;
    logic        zero;
    logic        illegal_op;

    int total = 0;
    int bad   = 0;

    rv_alu dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .B          (B),
        .ALUOp      (ALUOp),
        .in_valid   (in_valid),
        .ALURes     (ALURes),
        .out_valid  (out_valid),
        .zero       (zero),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present one op for one edge, then check all outputs #1 after that edge.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_ill);
        @(negedge clk);
        A        = a;
        B        = b;
        ALUOp    = op;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, ".res"}, ALURes, exp_res);
        check({tag, ".vld"}, 32'(out_valid), 32'd1);
        check({tag, ".zero"}, 32'(zero), 32'(exp_res == 32'd0));
        check({tag, ".ill"}, 32'(illegal_op), 32'(exp_ill));
    endtask

    initial begin
        rst      = 1'b1;
        A        = '0;
        B        = '0;
        ALUOp    = 4'b0000;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.res",  ALURes, 32'd0);
        check("rst.zero", 32'(zero), 32'd1);
        check("rst.ill",  32'(illegal_op), 32'd0);
        check("rst.vld",  32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add",      4'b0000, 32'd10,        32'd5,          32'd15,        1'b0);
        run_op("sub",      4'b1000, 32'd10,        32'd5,          32'd5,         1'b0);
        run_op("add_wrap", 4'b0000, 32'h7FFF_FFFF, 32'd1,          32'h8000_0000, 1'b0);
        run_op("sll",      4'b0001, 32'd1,         32'd2,          32'd4,         1'b0);
        run_op("srl",      4'b0101, 32'h10,        32'd2,          32'd4,         1'b0);
        run_op("sra",      4'b1101, 32'hF000_0000, 32'd4,          32'hFF00_0000, 1'b0);
        run_op("srl_neg",  4'b0101, 32'hF000_0000, 32'd4,          32'h0F00_0000, 1'b0);
        run_op("sll_mask", 4'b0001, 32'd1,         32'h21,         32'd2,         1'b0);
        run_op("sll_zero", 4'b0001, 32'h1234_5678, 32'h20,         32'h1234_5678, 1'b0);
        run_op("slt_gt",   4'b0010, 32'd5,         32'd1,          32'd0,         1'b0);
        run_op("slt_neg",  4'b0010, 32'hFFFF_FFFF, 32'd1,          32'd1,         1'b0);
        run_op("sltu_lt",  4'b0011, 32'd1,         32'hFFFF_FFFF,  32'd1,         1'b0);
        run_op("sltu_gt",  4'b0011, 32'hFFFF_FFFF, 32'd1,          32'd0,         1'b0);
        run_op("xor",      4'b0100, 32'hA,         32'h5,          32'hF,         1'b0);
        run_op("or",       4'b0110, 32'hA,         32'h5,          32'hF,         1'b0);
        run_op("mov",      4'b1111, 32'd1,         32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0);
        run_op("sub_zero", 4'b1000, 32'd7,         32'd7,          32'd0,         1'b0);
        run_op("illegal",  4'b1010, 32'd3,         32'd4,          32'd0,         1'b1);
        run_op("and",      4'b0111, 32'hFFFF_FFFF, 32'h0F0F_0F0F,  32'h0F0F_0F0F, 1'b0);

        // Idle with changing inputs: outputs hold, out_valid drops after one edge.
        @(negedge clk);
        A     = 32'd1;
        B     = 32'd1;
        ALUOp = 4'b0000;
        @(posedge clk);
        #1;
        check("hold1.res", ALURes, 32'h0F0F_0F0F);
        check("hold1.vld", 32'(out_valid), 32'd0);
        @(negedge clk);
        A     = 32'd0;
        B     = 32'd0;
        ALUOp = 4'b1010;
        @(posedge clk);
        #1;
        check("hold2.res",  ALURes, 32'h0F0F_0F0F);
        check("hold2.zero", 32'(zero), 32'd0);
        check("hold2.ill",  32'(illegal_op), 32'd0);
        check("hold2.vld",  32'(out_valid), 32'd0);

        // Reset beats a same-cycle valid operation.
        @(negedge clk);
        rst      = 1'b1;
        A        = 32'd10;
        B        = 32'd5;
        ALUOp    = 4'b0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("rstop.res",  ALURes, 32'd0);
        check("rstop.vld",  32'(out_valid), 32'd0);
        check("rstop.zero", 32'(zero), 32'd1);
        check("rstop.ill",  32'(illegal_op), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;

        run_op("post_rst", 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Backstop so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
